// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command/response stream and APB3 bus bundle for apb_cmd_master
// Purpose: groups the command stream, the response pulse and the APB3 requester signals.
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command stream into the requester
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout           one-cycle response out of the requester
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA                 APB requester outputs
//   PRDATA/PREADY/PSLVERR                             APB completer outputs
// Modports: master = requester view, slave = sequencer + APB completer view.
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 requester turning a valid/ready command stream into SETUP/ACCESS transfers
// Purpose: one APB3 transfer per accepted command, one response pulse per transfer
//          (read data, PSLVERR, or a local PREADY timeout).
// Ports:
//   PCLK     clock, rising edge
//   PRESETn  synchronous active-low reset
//   bus      apb_cmd_master_if.master: command stream in, response pulse out, APB3 requester side
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_cmd_master_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A zero limit still needs a one-bit counter so the saturating logic stays well formed.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic [CW-1:0]         r_wait_cnt;

    logic [CW-1:0]         w_cnt_inc;
    logic                  w_timeout_hit;

    // Saturating increment: the counter never wraps even when the limit is disabled.
    assign w_cnt_inc     = (r_wait_cnt == {CW{1'b1}}) ? r_wait_cnt : r_wait_cnt + CW'(1);
    // Abort when this wait cycle would bring the count up to the limit.
    assign w_timeout_hit = (TIMEOUT_CYCLES > 0) && (w_cnt_inc >= CW'(TIMEOUT_CYCLES));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite   <= bus.cmd_write;
                        r_paddr    <= bus.cmd_addr;
                        r_pwdata   <= bus.cmd_write ? bus.cmd_wdata : '0;
                        r_psel     <= 1'b1;
                        r_penable  <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY wins over a timeout reached on the same edge.
                    if (bus.PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_state       <= ST_IDLE;
                    end else if (w_timeout_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_wait_cnt    <= w_cnt_inc;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == ST_IDLE);
    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
